fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO: the next generation of the FIFO next-state controller, now with the storage array, pointers and per-operation handshake flags in one block.
- Generalised in data width and depth.
- Adds simultaneous read+write as a legal operation with its own state.
- Used wherever a single-clock buffer is needed; the FSM state is exported for debug and for existing state-display benches.

Parameters:
DATA_WIDTH, 8, width of din/dout in bits
DEPTH, 8, number of entries; must be a power of 2 and at least 2
AF_MARGIN, 1, almost_full asserts when data_count >= DEPTH-AF_MARGIN (only used with FIFO_ALMOST_EN)
AE_MARGIN, 1, almost_empty asserts when data_count <= AE_MARGIN (only used with FIFO_ALMOST_EN)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
rd_en  input  1  read request
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read data, registered
data_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  data_count==DEPTH, combinational from the count
empty  output  1  data_count==0, combinational from the count
wr_ack  output  1  registered; the previous cycle's write was accepted
wr_err  output  1  registered; the previous cycle's write was rejected because the FIFO was full
rd_ack  output  1  registered; the previous cycle's read was accepted and dout is updated
rd_err  output  1  registered; the previous cycle's read was rejected because the FIFO was empty
almost_full  output  1  see Optional Feature
almost_empty  output  1  see Optional Feature
state  output  3  current FSM state

Behaviour:
- Reset (async, rst=1):
  - state=INIT
  - wr_ptr=0, rd_ptr=0, data_count=0
  - dout=0
  - all ack/err flags 0
  - memory contents are not reset
- State encoding:
  - INIT=3'b000, WRITE=3'b001, WR_ERR=3'b010, NO_OP=3'b011
  - READ=3'b100, RD_ERR=3'b101, RD_WR=3'b110
  - 3'b111 is unreachable; if seen, the next state is NO_OP.
- Next state is combinational from wr_en, rd_en and data_count, and is registered on the clk edge. The transition is the same from every current state:
  - !wr_en & !rd_en → NO_OP
  - wr_en & !rd_en → WRITE if !full, else WR_ERR
  - !wr_en & rd_en → READ if !empty, else RD_ERR
  - wr_en & rd_en & !empty → RD_WR. Applies when full too: the read frees a slot in the same edge.
  - wr_en & rd_en & empty → WRITE. The read is dropped, rd_err=1, wr_ack=1.
- Datapath on the same edge as the state update:
  - Accepted write: mem[wr_ptr]<=din; wr_ptr+1.
  - Accepted read: dout<=mem[rd_ptr]; rd_ptr+1.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- data_count update: +1 on WRITE, -1 on READ, unchanged on RD_WR, NO_OP or either error.
- Rejected operations change no pointer, no count, no memory and no dout.
- Flags are one-cycle registered pulses, valid in the cycle after the request edge.
  - Exactly the flags for the operation just performed are 1; all others are 0.
  - RD_WR gives wr_ack=1 and rd_ack=1.
- Read latency: dout is valid in the same cycle rd_ack=1. dout holds its value otherwise.
- Reset mid-operation: everything returns to reset values immediately. No partial write persists in the pointers.
- INIT is left on the first clk edge after rst deasserts, according to the transition rules above.

Optional Feature:
- Macro: FIFO_ALMOST_EN.
- Defined: almost_full and almost_empty are combinational compares of data_count against AF_MARGIN and AE_MARGIN. Both are 0 during reset.
- Undefined: both ports are tied to 0 and no compare logic is built. The port list is identical either way.

Decomposition:
- Package fifo_pkg holds:
  - state localparams INIT..RD_WR
  - the 3-bit state width constant
- One natural sub-module, fifo_ns_p: the parametrised next-state logic.
  - Inputs: wr_en, rd_en, state, data_count.
  - Output: next_state.
  - Parameter: DEPTH.
- The top holds the state register, memory, pointers, count and flags.

Test Plan (DATA_WIDTH=8, DEPTH=8):
- Reset, then rd_en=1 for one cycle → state=RD_ERR, rd_err=1, data_count=0, dout=0.
- Write 0x11..0x88 over 8 cycles → data_count=8, full=1; a 9th write → WR_ERR, wr_err=1, count stays 8.
- Read 8 times → dout sequence 0x11..0x88 with rd_ack=1 each cycle, empty=1 after the last read. Pointer wrap: write 3 more → count=3, rd_ptr and wr_ptr have wrapped.
- At full, wr_en=rd_en=1 with din=0xAA → RD_WR, wr_ack=rd_ack=1, count stays 8, dout=oldest entry. At empty, wr_en=rd_en=1 → WRITE, wr_ack=1, rd_err=1, count=1.
- Assert rst mid-burst at count=5 → state=INIT, count=0 and all flags 0 asynchronously, before the next clk edge.
- With FIFO_ALMOST_EN: count=7 → almost_full=1; count=1 → almost_empty=1. Without the macro, both stay 0 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FSM encoding for the parametrised FIFO and its next-state logic.
package fifo_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    INIT   = 3'b000,
    WRITE  = 3'b001,
    WR_ERR = 3'b010,
    NO_OP  = 3'b011,
    READ   = 3'b100,
    RD_ERR = 3'b101,
    RD_WR  = 3'b110
  } state_t;

endpackage

// File: rtl/fifo_ns_p.sv
// Next-state logic for fifo_param: a pure function of the request pair and
// the occupancy, except the unused encoding which always recovers to NO_OP.
import fifo_pkg::*;

module fifo_ns_p #(
  parameter int DEPTH = 8
) (
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [STATE_W-1:0]       state,
  input  logic [$clog2(DEPTH):0]   data_count,
  output state_t                   next_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic isFull;
  logic isEmpty;

  assign isFull  = (data_count == CW'(DEPTH));
  assign isEmpty = (data_count == '0);

  always_comb begin
    next_state = NO_OP;
    if (!(&state)) begin
      case ({wr_en, rd_en})
        2'b00:   next_state = NO_OP;
        2'b10:   next_state = isFull  ? WR_ERR : WRITE;
        2'b01:   next_state = isEmpty ? RD_ERR : READ;
        // A simultaneous request on an empty FIFO degrades to a plain write.
        default: next_state = isEmpty ? WRITE  : RD_WR;
      endcase
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with exported FSM state and registered
// handshake flags. Define FIFO_ALMOST_EN to build the almost_full/empty compares.
import fifo_pkg::*;

module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [$clog2(DEPTH):0]  data_count,
  output logic                    full,
  output logic                    empty,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic                    rd_ack,
  output logic                    rd_err,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [STATE_W-1:0]      state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, nextState;
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wrAck_q, wrAck_d;
  logic                  wrErr_q, wrErr_d;
  logic                  rdAck_q, rdAck_d;
  logic                  rdErr_q, rdErr_d;
  logic                  memWe;

  fifo_ns_p #(
    .DEPTH(DEPTH)
  ) u_ns (
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .state     (state_q),
    .data_count(count_q),
    .next_state(nextState)
  );

  // Datapath effects are keyed off the state being entered, so state,
  // pointers, count and flags all move together on one edge.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    dout_d  = dout_q;
    wrAck_d = 1'b0;
    wrErr_d = 1'b0;
    rdAck_d = 1'b0;
    rdErr_d = 1'b0;
    memWe   = 1'b0;
    case (nextState)
      WRITE: begin
        memWe   = 1'b1;
        wrPtr_d = wrPtr_q + AW'(1);
        count_d = count_q + CW'(1);
        wrAck_d = 1'b1;
        rdErr_d = rd_en;
      end
      WR_ERR: wrErr_d = 1'b1;
      READ: begin
        dout_d  = mem[rdPtr_q];
        rdPtr_d = rdPtr_q + AW'(1);
        count_d = count_q - CW'(1);
        rdAck_d = 1'b1;
      end
      RD_ERR: rdErr_d = 1'b1;
      RD_WR: begin
        memWe   = 1'b1;
        dout_d  = mem[rdPtr_q];
        wrPtr_d = wrPtr_q + AW'(1);
        rdPtr_d = rdPtr_q + AW'(1);
        wrAck_d = 1'b1;
        rdAck_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      wrAck_q <= 1'b0;
      wrErr_q <= 1'b0;
      rdAck_q <= 1'b0;
      rdErr_q <= 1'b0;
    end else begin
      state_q <= nextState;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      wrAck_q <= wrAck_d;
      wrErr_q <= wrErr_d;
      rdAck_q <= rdAck_d;
      rdErr_q <= rdErr_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (memWe && !rst) begin
      mem[wrPtr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign data_count = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign wr_ack     = wrAck_q;
  assign wr_err     = wrErr_q;
  assign rd_ack     = rdAck_q;
  assign rd_err     = rdErr_q;
  assign state      = state_q;

`ifdef FIFO_ALMOST_EN
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);

  assign almost_full  = !rst && (count_q >= AF_LEVEL);
  assign almost_empty = !rst && (count_q <= AE_LEVEL);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DATA_WIDTH=8, DEPTH=8).
// Expected almost_* values follow FIFO_ALMOST_EN when it is defined.
import fifo_pkg::*;

module tb_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [3:0]    data_count;
  logic          full, empty;
  logic          wr_ack, wr_err, rd_ack, rd_err;
  logic          almost_full, almost_empty;
  logic [2:0]    state;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

`ifdef FIFO_ALMOST_EN
  localparam bit ALMOST_EN = 1'b1;
`else
  localparam bit ALMOST_EN = 1'b0;
`endif

  fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .din         (din),
    .dout        (dout),
    .data_count  (data_count),
    .full        (full),
    .empty       (empty),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .rd_ack      (rd_ack),
    .rd_err      (rd_err),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after each rising edge and outputs are
  // sampled at the same point, well away from the active edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic wa, input logic we,
                            input logic ra, input logic re);
    checkOutput({tag, ".wr_ack"}, 32'(wr_ack), 32'(wa));
    checkOutput({tag, ".wr_err"}, 32'(wr_err), 32'(we));
    checkOutput({tag, ".rd_ack"}, 32'(rd_ack), 32'(ra));
    checkOutput({tag, ".rd_err"}, 32'(rd_err), 32'(re));
  endtask

  task automatic checkLevel(input string tag, input int cnt);
    checkOutput({tag, ".count"}, 32'(data_count), 32'(cnt));
    checkOutput({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    checkOutput({tag, ".afull"}, 32'(almost_full), 32'(ALMOST_EN && cnt >= DEPTH - 1));
    checkOutput({tag, ".aempty"}, 32'(almost_empty), 32'(ALMOST_EN && cnt <= 1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge has occurred.
    #1 rst = 1'b1;
    #2;
    checkOutput("rst.state", 32'(state), 32'(INIT));
    checkOutput("rst.dout", 32'(dout), 32'h0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.count", 32'(data_count), 32'h0);
    checkOutput("rst.empty", 32'(empty), 32'h1);
    checkOutput("rst.afull", 32'(almost_full), 32'h0);
    checkOutput("rst.aempty", 32'(almost_empty), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post_rst.state", 32'(state), 32'(INIT));

    // Read from empty.
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("rderr.state", 32'(state), 32'(RD_ERR));
    checkFlags("rderr", 1'b0, 1'b0, 1'b0, 1'b1);
    checkLevel("rderr", 0);
    checkOutput("rderr.dout", 32'(dout), 32'h0);

    // Fill with 0x11..0x88.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
      checkOutput($sformatf("wr%0d.state", i), 32'(state), 32'(WRITE));
      checkFlags($sformatf("wr%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      checkLevel($sformatf("wr%0d", i), i + 1);
    end

    // Write while full is rejected.
    applyStimulus(1'b1, 1'b0, 8'h99);
    checkOutput("wrerr.state", 32'(state), 32'(WR_ERR));
    checkFlags("wrerr", 1'b0, 1'b1, 1'b0, 1'b0);
    checkLevel("wrerr", 8);
    checkOutput("wrerr.dout", 32'(dout), 32'h0);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("rd%0d.state", i), 32'(state), 32'(READ));
      checkFlags($sformatf("rd%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("rd%0d.dout", i), 32'(dout), 32'(8'h11 * (i + 1)));
      checkLevel($sformatf("rd%0d", i), DEPTH - 1 - i);
    end

    // Pointers have wrapped; three more entries come back in order.
    applyStimulus(1'b1, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b0, 8'hA2);
    applyStimulus(1'b1, 1'b0, 8'hA3);
    checkLevel("wrap", 3);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap.rd0", 32'(dout), 32'hA1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap.rd1", 32'(dout), 32'hA2);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap.rd2", 32'(dout), 32'hA3);
    checkLevel("wrap.end", 0);

    // Simultaneous read+write while full.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i + 1));
    end
    checkLevel("fill2", 8);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("rdwr.state", 32'(state), 32'(RD_WR));
    checkFlags("rdwr", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rdwr.dout", 32'(dout), 32'h01);
    checkLevel("rdwr", 8);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("rdwr_drain%0d.dout", i), 32'(dout),
                  (i == DEPTH - 1) ? 32'hAA : 32'(i + 2));
    end
    checkLevel("rdwr_drain", 0);

    // Simultaneous read+write while empty degrades to a write.
    applyStimulus(1'b1, 1'b1, 8'h55);
    checkOutput("rdwr_empty.state", 32'(state), 32'(WRITE));
    checkFlags("rdwr_empty", 1'b1, 1'b0, 1'b0, 1'b1);
    checkLevel("rdwr_empty", 1);
    checkOutput("rdwr_empty.dout", 32'(dout), 32'hAA);

    // Idle cycle clears every flag.
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("noop.state", 32'(state), 32'(NO_OP));
    checkFlags("noop", 1'b0, 1'b0, 1'b0, 1'b0);
    checkLevel("noop", 1);

    // Reset in the middle of a burst at count 5.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i));
    end
    checkLevel("burst", 5);
    wr_en = 1'b1;
    din   = 8'hEE;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.state", 32'(state), 32'(INIT));
    checkFlags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst.count", 32'(data_count), 32'h0);
    checkOutput("midrst.dout", 32'(dout), 32'h0);
    checkOutput("midrst.afull", 32'(almost_full), 32'h0);
    checkOutput("midrst.aempty", 32'(almost_empty), 32'h0);
    wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("after_rst.state", 32'(state), 32'(NO_OP));
    checkLevel("after_rst", 0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("after_rst.rd.state", 32'(state), 32'(RD_ERR));
    applyStimulus(1'b1, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("after_rst.dout", 32'(dout), 32'h77);
    checkLevel("after_rst.end", 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
